// File: rtl/first_lab_regfile.sv
// 32 x 32-bit register file: one write port, two registered read ports, one op per clock.
// Optional REGFILE_X0_ZERO_EN makes x0 hard-wired to zero (RISC-V semantics).
module first_lab_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32   // must equal 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] rs1_out,
    output logic [DATA_WIDTH-1:0] rs2_out
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] rs1_rdata;
    logic [DATA_WIDTH-1:0] rs2_rdata;
    logic                  wr_allowed;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        rs1_rdata  = regs[rs1];
        rs2_rdata  = regs[rs2];
        wr_allowed = 1'b1;
`ifdef REGFILE_X0_ZERO_EN
        if (rs1 == '0) rs1_rdata = '0;
        if (rs2 == '0) rs2_rdata = '0;
        if (rd == '0)  wr_allowed = 1'b0;
`endif
    end

    // NOTE: the storage array has a reset because every register must read 0 after reset;
    // that rules out a RAM macro, which is acceptable at 32 entries.
    // NOTE: state is updated with non-blocking assignments so all registers sample together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            rs1_out <= '0;
            rs2_out <= '0;
        end else if (read == 1'b1) begin
            rs1_out <= rs1_rdata;
            rs2_out <= rs2_rdata;
        end else if (read == 1'b0) begin
            // An unknown read level falls through both branches: nothing changes.
            if (wr_allowed) begin
                regs[rd] <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_first_lab_regfile.sv
// Self-checking bench for first_lab_regfile: directed plan scenarios plus randomized
// traffic checked against an array-based reference model. Honors REGFILE_X0_ZERO_EN.
module tb_first_lab_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] data_in;
    logic        read;
    logic [31:0] rs1_out;
    logic [31:0] rs2_out;

    int checks = 0;
    int errors = 0;

    // Reference model: plain array of register values plus the expected output latches.
    logic [31:0] model_regs [32];
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;

    first_lab_regfile dut (
        .clk     (clk),
        .rst     (rst),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .data_in (data_in),
        .read    (read),
        .rs1_out (rs1_out),
        .rs2_out (rs2_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [4:0] addr);
`ifdef REGFILE_X0_ZERO_EN
        if (addr == 5'd0) return 32'd0;
`endif
        return model_regs[addr];
    endfunction

    task automatic model_write(input logic [4:0] addr, input logic [31:0] d);
`ifdef REGFILE_X0_ZERO_EN
        if (addr == 5'd0) return;
`endif
        model_regs[addr] = d;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        exp_rs1 = 32'd0;
        exp_rs2 = 32'd0;
    endtask

    // Called at a falling edge: drive one operation, let one rising edge take it,
    // update the model, and return at the following falling edge.
    task automatic cycle(input logic op_read, input logic [4:0] w_addr,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] d);
        read    = op_read;
        rd      = w_addr;
        rs1     = a1;
        rs2     = a2;
        data_in = d;
        @(posedge clk);
        if (op_read) begin
            exp_rs1 = model_read(a1);
            exp_rs2 = model_read(a2);
        end else begin
            model_write(w_addr, d);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; read = 1'b1; rs1 = 5'd5; rs2 = 5'd9; rd = 5'd0; data_in = 32'd0;
        model_reset();
        @(negedge clk);
        checks++;
        if (rs1_out !== 32'd0 || rs2_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold: rs1_out=%h rs2_out=%h expected 0/0", rs1_out, rs2_out);
        end
        rst = 1'b1;
        cycle(1'b1, 5'd0, 5'd5, 5'd9, 32'd0);
        checks++;
        if (rs1_out !== 32'd0 || rs2_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_release: rs1_out=%h rs2_out=%h expected 0/0", rs1_out, rs2_out);
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 5'd0, 5'(i), 5'(i + 16), 32'd0);
            checks++;
            if (rs1_out !== 32'd0 || rs2_out !== 32'd0) begin
                errors++;
                $display("FAIL reset_regs x%0d/x%0d: got %h/%h expected 0/0",
                         i, i + 16, rs1_out, rs2_out);
            end
        end
    endtask

    task automatic test_write_read();
        cycle(1'b0, 5'd1, 5'd0, 5'd0, 32'd50);
        cycle(1'b0, 5'd27, 5'd0, 5'd0, 32'd25);
        cycle(1'b1, 5'd0, 5'd1, 5'd27, 32'd0);
        checks++;
        if (rs1_out !== 32'd50 || rs2_out !== 32'd25) begin
            errors++;
            $display("FAIL write_read: got %0d/%0d expected 50/25", rs1_out, rs2_out);
        end
    endtask

    task automatic test_interleaved();
        cycle(1'b0, 5'd3, 5'd0, 5'd0, 32'd5);
        checks++;
        if (rs1_out !== 32'd50 || rs2_out !== 32'd25) begin
            errors++;
            $display("FAIL hold_on_write: got %0d/%0d expected 50/25", rs1_out, rs2_out);
        end
        cycle(1'b1, 5'd0, 5'd1, 5'd3, 32'd0);
        checks++;
        if (rs1_out !== 32'd50 || rs2_out !== 32'd5) begin
            errors++;
            $display("FAIL interleave_1: got %0d/%0d expected 50/5", rs1_out, rs2_out);
        end
        cycle(1'b0, 5'd9, 5'd0, 5'd0, 32'h1234);
        checks++;
        if (rs1_out !== 32'd50 || rs2_out !== 32'd5) begin
            errors++;
            $display("FAIL hold_on_write_2: got %0d/%0d expected 50/5", rs1_out, rs2_out);
        end
        cycle(1'b1, 5'd0, 5'd27, 5'd3, 32'd0);
        checks++;
        if (rs1_out !== 32'd25 || rs2_out !== 32'd5) begin
            errors++;
            $display("FAIL interleave_2: got %0d/%0d expected 25/5", rs1_out, rs2_out);
        end
    endtask

    task automatic test_same_address();
        cycle(1'b1, 5'd0, 5'd27, 5'd27, 32'd0);
        checks++;
        if (rs1_out !== 32'd25 || rs2_out !== 32'd25) begin
            errors++;
            $display("FAIL same_addr: got %0d/%0d expected 25/25", rs1_out, rs2_out);
        end
        cycle(1'b0, 5'd27, 5'd0, 5'd0, 32'hDEADBEEF);
        cycle(1'b1, 5'd0, 5'd27, 5'd27, 32'd0);
        checks++;
        if (rs1_out !== 32'hDEADBEEF || rs2_out !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL same_addr_overwrite: got %h/%h expected deadbeef/deadbeef",
                     rs1_out, rs2_out);
        end
    endtask

    task automatic test_x0();
        logic [31:0] want;
`ifdef REGFILE_X0_ZERO_EN
        want = 32'd0;
`else
        want = 32'hFFFFFFFF;
`endif
        cycle(1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
        cycle(1'b1, 5'd0, 5'd0, 5'd1, 32'd0);
        checks++;
        if (rs1_out !== want || rs2_out !== 32'd50) begin
            errors++;
            $display("FAIL x0_write: got %h/%h expected %h/00000032", rs1_out, rs2_out, want);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
            checks++;
            if (rs1_out !== exp_rs1 || rs2_out !== exp_rs2) begin
                errors++;
                $display("FAIL random[%0d]: got %h/%h expected %h/%h",
                         n, rs1_out, rs2_out, exp_rs1, exp_rs2);
            end
        end
        // Full sweep so every stored value is compared at least once.
        for (int i = 0; i < 32; i += 2) begin
            cycle(1'b1, 5'd0, 5'(i), 5'(i + 1), 32'd0);
            checks++;
            if (rs1_out !== exp_rs1 || rs2_out !== exp_rs2) begin
                errors++;
                $display("FAIL sweep x%0d/x%0d: got %h/%h expected %h/%h",
                         i, i + 1, rs1_out, rs2_out, exp_rs1, exp_rs2);
            end
        end
    endtask

    task automatic test_mid_reset();
        cycle(1'b0, 5'd1, 5'd0, 5'd0, 32'd50);
        cycle(1'b1, 5'd0, 5'd1, 5'd1, 32'd0);
        checks++;
        if (rs1_out !== 32'd50 || rs2_out !== 32'd50) begin
            errors++;
            $display("FAIL pre_reset_read: got %0d/%0d expected 50/50", rs1_out, rs2_out);
        end
        // Pending write to x2 must be lost because reset covers its edge.
        read = 1'b0; rd = 5'd2; data_in = 32'd77;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (rs1_out !== 32'd0 || rs2_out !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got %0d/%0d expected 0/0", rs1_out, rs2_out);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 5'd0, 5'd1, 5'd2, 32'd0);
        checks++;
        if (rs1_out !== 32'd0 || rs2_out !== 32'd0) begin
            errors++;
            $display("FAIL post_reset_read: got %0d/%0d expected 0/0", rs1_out, rs2_out);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_interleaved();
        test_same_address();
        test_x0();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
